// File: rtl/kp_serializer_if.sv
// Handshake/data bundle between a kP result source and the nibble serializer.
// Widths follow NIBBLES; master drives the request side, slave is the serializer.
interface kp_serializer_if #(
    parameter int NIBBLES = 8
) ();
    logic                   start;
    logic [4*NIBBLES-1:0]   res_x;
    logic [4*NIBBLES-1:0]   res_y;
    logic                   hold;
    logic                   busy;
    logic                   ready;
    logic [3:0]             kP;
    logic                   done;

    modport master (
        output start, res_x, res_y, hold,
        input  busy, ready, kP, done
    );

    modport slave (
        input  start, res_x, res_y, hold,
        output busy, ready, kP, done
    );
endinterface

// File: rtl/kp_serializer.sv
// Serializes a kP (x, y) result pair as two frames: header beat, then NIBBLES nibbles MSB first.
// Optional macro KP_PARITY_EN appends one XOR-parity beat to each frame.
module kp_serializer #(
    parameter int NIBBLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    kp_serializer_if.slave    bus
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            frame;      // 0 = X frame, 1 = Y frame
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sx;
    logic [W-1:0]    sy;
    logic            done_q;
    logic [3:0]      cur_nib;
    logic            last_beat;
    logic            frame_end;
    logic            ready_c;
    logic            busy_c;
    logic [3:0]      kp_c;
`ifdef KP_PARITY_EN
    logic [3:0]      par_q;
`endif

    assign cur_nib   = frame ? sy[W-1 -: 4] : sx[W-1 -: 4];
    assign last_beat = (cnt == LAST);

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        kp_c      = 4'h0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = HDR;
            end
            HDR: begin
                busy_c  = 1'b1;
                ready_c = 1'b1;
                if (!bus.hold) state_nxt = DATA;
            end
            DATA: begin
                busy_c = 1'b1;
                kp_c   = cur_nib;
                if (!bus.hold && last_beat) begin
`ifdef KP_PARITY_EN
                    state_nxt = PAR;
`else
                    frame_end = 1'b1;
                    state_nxt = frame ? IDLE : HDR;
`endif
                end
            end
            PAR: begin
`ifdef KP_PARITY_EN
                busy_c = 1'b1;
                kp_c   = par_q;
                if (!bus.hold) begin
                    frame_end = 1'b1;
                    state_nxt = frame ? IDLE : HDR;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift registers are cleared by reset too, so an abandoned
    // transfer leaves no stale operand behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame  <= 1'b0;
            cnt    <= '0;
            sx     <= '0;
            sy     <= '0;
            done_q <= 1'b0;
`ifdef KP_PARITY_EN
            par_q  <= 4'h0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sx    <= bus.res_x;
                        sy    <= bus.res_y;
                        frame <= 1'b0;
                        cnt   <= '0;
                    end
                end
                HDR: begin
                    if (!bus.hold) begin
                        cnt <= '0;
`ifdef KP_PARITY_EN
                        par_q <= 4'h0;
`endif
                    end
                end
                DATA: begin
                    if (!bus.hold) begin
                        if (frame) sy <= {sy[W-5:0], 4'h0};
                        else       sx <= {sx[W-5:0], 4'h0};
                        cnt <= cnt + CW'(1);
`ifdef KP_PARITY_EN
                        par_q <= par_q ^ cur_nib;
`endif
                    end
                end
                default: ;
            endcase
            // The Y frame ending is what raises done on the first IDLE cycle.
            if (frame_end) begin
                if (frame) done_q <= 1'b1;
                else       frame  <= 1'b1;
            end
        end
    end

    assign bus.ready = ready_c;
    assign bus.busy  = busy_c;
    assign bus.kP    = kp_c;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_kp_serializer.sv
// Directed bench for kp_serializer: framing, hold stall, ignored start, reset abort, back-to-back.
// Parity beats are expected when KP_PARITY_EN is defined for the build.
module tb_kp_serializer;

    localparam int NIB = 8;
`ifdef KP_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    kp_serializer_if #(.NIBBLES(NIB)) bus ();

    kp_serializer #(.NIBBLES(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Observed output vector: {busy, ready, done, kP}
    function automatic logic [6:0] snap();
        return {bus.busy, bus.ready, bus.done, bus.kP};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={busy,ready,done,kP}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts a transfer from a negedge and walks the expected beat sequence.
    task automatic run_pair(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input int hold_at, input int hold_len, input int bogus_at,
                            input int abort_at, input bit b2b);
        logic [6:0]  exp[$];
        logic [31:0] w;
        logic [3:0]  nib;
        logic [3:0]  p;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? x : y;
            p = 4'h0;
            exp.push_back(7'b110_0000);
            for (int i = 0; i < NIB; i++) begin
                nib = w[4*NIB-1-4*i -: 4];
                p   = p ^ nib;
                exp.push_back({3'b100, nib});
            end
`ifdef KP_PARITY_EN
            exp.push_back({3'b100, p});
`endif
        end
        exp.push_back(7'b001_0000);

        bus.res_x = x;
        bus.res_y = y;
        bus.start = 1'b1;
        @(posedge clk);
        for (int idx = 0; idx < exp.size(); idx++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (idx == bogus_at) begin
                bus.res_x = '1;
                bus.start = 1'b1;
            end
            check($sformatf("%s beat%0d", tag, idx), snap(), exp[idx]);
            if (idx == abort_at) begin
                rst = 1'b0;
                #1;
                check($sformatf("%s async_reset", tag), snap(), 7'h00);
                return;
            end
            if (idx == hold_at) begin
                bus.hold = 1'b1;
                for (int h = 0; h < hold_len; h++) begin
                    @(negedge clk);
                    check($sformatf("%s held%0d", tag, h), snap(), exp[idx]);
                end
                bus.hold = 1'b0;
            end
        end
        if (!b2b) begin
            @(negedge clk);
            check($sformatf("%s idle_after_done", tag), snap(), 7'h00);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.res_x = '0;
        bus.res_y = '0;

        #12;
        check("reset_state", snap(), 7'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_release", snap(), 7'h00);

        bus.hold = 1'b1;
        @(negedge clk);
        check("hold_in_idle", snap(), 7'h00);
        bus.hold = 1'b0;

        // x/y pair framing, done 2*(NIB+1+PB)+1 cycles after load
        run_pair("basic", 32'h1234_5678, 32'h9ABC_DEF0, -1, 0, -1, -1, 1'b0);

        // Stall for three cycles while kP shows 0x5 (beat index 5)
        run_pair("hold", 32'h1234_5678, 32'h9ABC_DEF0, 5, 3, -1, -1, 1'b0);

        // Start with all-ones x mid-frame must be ignored
        run_pair("ignore", 32'h1234_5678, 32'h9ABC_DEF0, -1, 0, 3, -1, 1'b0);

        // Reset during frame Y beat 4, then no done pulse and a clean restart
        run_pair("abort", 32'h1234_5678, 32'h9ABC_DEF0, -1, 0, -1, NIB + 1 + PB + 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("in_reset%0d", i), snap(), 7'h00);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), snap(), 7'h00);
        end
        run_pair("after_reset", 32'hCAFE_BABE, 32'h0F1E_2D3C, -1, 0, -1, -1, 1'b0);

        // Back-to-back: new start on the done cycle gives a header next cycle
        run_pair("b2b_first", 32'h1234_5678, 32'h9ABC_DEF0, -1, 0, -1, -1, 1'b1);
        run_pair("b2b_second", 32'h0000_0000, 32'h0000_0001, -1, 0, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kp_serializer.md
KP_SERIALIZER -- requirements
Module: kp_serializer

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, number of 4-bit digits per word (word width 4*NIBBLES).
REQ-002 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have port start  in  1  load request for a result pair.
REQ-005 SHALL have port res_x  in  4*NIBBLES  kP x-coordinate, sampled on load.
REQ-006 SHALL have port res_y  in  4*NIBBLES  kP y-coordinate, sampled on load.
REQ-007 SHALL have port hold  in  1  downstream stall; freezes transmission.
REQ-008 SHALL have port busy  out  1  high from the load edge until the return to IDLE.
REQ-009 SHALL have port ready  out  1  frame header strobe, one beat per frame.
REQ-010 SHALL have port kP  out  4  serial nibble output.
REQ-011 SHALL have port done  out  1  one-cycle pulse after the last beat of frame Y.

Function
REQ-012 SHALL implement FSM states IDLE, HDR, DATA, PAR, plus a frame-select bit (X=0, Y=1) and a digit counter of width clog2(NIBBLES+1).
REQ-013 SHALL load res_x/res_y into internal shift registers, clear frame-select and counter, and enter HDR when start=1 in IDLE; start in any other state SHALL be ignored.
REQ-014 SHALL drive ready=1 and kP=0 for exactly one unstalled cycle in HDR, then enter DATA.
REQ-015 SHALL drive in DATA, on NIBBLES consecutive unstalled cycles, the selected word's nibbles MSB first (bits [4N-1:4N-4] first), with ready=0.
REQ-016 SHALL, after the last DATA nibble, go to PAR if KP_PARITY_EN is defined; otherwise go to HDR with frame Y if frame=X, or to IDLE if frame=Y.
REQ-017 SHALL pulse done=1 for one cycle on the first IDLE cycle after frame Y completes.
REQ-018 SHALL drive kP=0, ready=0 and busy=0 in IDLE.
REQ-019 SHALL, while hold=1 in HDR/DATA/PAR, hold state, counter, shift registers, kP and ready unchanged; transmission SHALL resume on the cycle after hold returns to 0.
REQ-020 SHALL ignore hold in IDLE.
REQ-021 SHALL accept start on the same cycle done is asserted (back-to-back), giving a header on the following cycle.
REQ-022 Total unstalled latency, load edge to done, SHALL be 2*(NIBBLES+1)+1 cycles (2*(NIBBLES+2)+1 with parity).
REQ-023 SHALL serve as the transmit counterpart of the nibble receiver: ready acts as the receiver's valid, followed by NIBBLES nibbles MSB first.

Reset
REQ-024 SHALL, when rst=0, immediately force IDLE, frame=X, counter=0, shift registers=0, kP=0, ready=0, busy=0, done=0.
REQ-025 SHALL abandon any in-progress frame on reset mid-operation, with no done pulse; after release, only a new start SHALL begin a transfer.

Configuration
REQ-026 SHALL honour macro KP_PARITY_EN: when defined, each frame SHALL append one PAR beat with kP = XOR of that frame's NIBBLES nibbles, ready=0, stallable by hold; when undefined, PAR SHALL be unreachable and frames SHALL be header + NIBBLES beats.

Verification
REQ-027 Reset, then start with x=0x12345678, y=0x9ABCDEF0 -> ready, 1,2,3,4,5,6,7,8, ready, 9,A,B,C,D,E,F,0, then done on cycle 19 after load.
REQ-028 KP_PARITY_EN defined, same operands -> parity beat 0x8 after frame X and 0x8 after frame Y; done at cycle 21.
REQ-029 hold=1 for 3 cycles while kP=0x5 -> kP stays 0x5 for 3 extra cycles, then 0x6; done delayed by exactly 3 cycles.
REQ-030 start pulsed mid-frame with x=0xFFFFFFFF -> ignored; original data transmitted unchanged.
REQ-031 rst=0 during frame Y beat 4 -> kP=0, ready=0, busy=0 asynchronously; no done; subsequent start transmits correctly.
REQ-032 start asserted during done cycle with x=0, y=0x1 -> header on the next cycle, frame Y last nibble = 0x1.
